// File: rtl/lcd_digit_writer.sv
// lcd_digit_writer
// Writes the two BCD countdown digits to an HD44780-compatible character LCD
// over the 8-bit parallel bus. After reset it waits for LCD power-up, runs the
// four-command initialisation, and then rewrites DDRAM positions 0 and 1
// whenever either digit differs from the last value it displayed.
module lcd_digit_writer #(
  parameter int unsigned T_PWRON = 750000,
  parameter int unsigned T_SU    = 2,
  parameter int unsigned T_PW    = 12,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_tens,
  input  logic [3:0] digit_units,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       init_done,
  output logic       busy
);

  // The single shared down-counter must hold the longest wait in the design.
  localparam int unsigned CNT_MAX = (T_PWRON > T_CLR) ? T_PWRON : T_CLR;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_PWRON = CNT_W'(T_PWRON - 1);
  localparam logic [CNT_W-1:0] LD_SU    = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);

  // HD44780 commands used by this block.
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment address, no shift
  localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (long execution)
  localparam logic [7:0] CMD_DDRAM0   = 8'h80;  // set DDRAM address 0

  localparam logic [1:0] INIT_LAST_STEP    = 2'd3;
  localparam logic [1:0] REFRESH_LAST_STEP = 2'd2;

  typedef enum logic [1:0] {
    ST_PWRON   = 2'd0,
    ST_INIT    = 2'd1,
    ST_IDLE    = 2'd2,
    ST_REFRESH = 2'd3
  } top_state_t;

  typedef enum logic [1:0] {
    W_SU = 2'd0,
    W_PW = 2'd1,
    W_EX = 2'd2
  } wr_state_t;

  // ASCII for a BCD digit; non-decimal codes show as '-'.
  function automatic logic [7:0] bcd_to_char(input logic [3:0] d);
    logic [7:0] c;
    if (d <= 4'd9) begin
      c = 8'h30 + {4'h0, d};
    end else begin
      c = 8'h2D;
    end
    return c;
  endfunction

  // Initialisation command table, issued in index order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = CMD_FUNC_SET;
      2'd1:    c = CMD_DISP_ON;
      2'd2:    c = CMD_ENTRY;
      2'd3:    c = CMD_CLEAR;
      default: c = CMD_FUNC_SET;
    endcase
    return c;
  endfunction

  top_state_t       top_state_r;
  wr_state_t        wr_state_r;
  logic [1:0]       step_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       snap_tens_r;
  logic [3:0]       snap_units_r;
  logic [7:0]       lcd_data_r;
  logic             lcd_rs_r;
  logic             lcd_e_r;
  logic             init_done_r;
  logic             busy_r;

  logic [7:0]       next_data_s;
  logic             next_rs_s;
  logic             last_step_s;
  logic             is_clear_s;
  logic             digit_change_s;
  logic             cnt_done_s;

  assign cnt_done_s     = (cnt_r == CNT_ZERO);
  assign is_clear_s     = (lcd_rs_r == 1'b0) && (lcd_data_r == CMD_CLEAR);
  assign digit_change_s = (digit_tens != snap_tens_r) || (digit_units != snap_units_r);

  // Pick the bus value for the write after the current one and flag the last write of a sequence.
  always_comb begin
    next_data_s = 8'h00;
    next_rs_s   = 1'b0;
    last_step_s = 1'b0;
    if (top_state_r == ST_INIT) begin
      last_step_s = (step_r == INIT_LAST_STEP);
      next_data_s = init_cmd(step_r + 2'd1);
      next_rs_s   = 1'b0;
    end else if (top_state_r == ST_REFRESH) begin
      last_step_s = (step_r == REFRESH_LAST_STEP);
      next_rs_s   = 1'b1;
      if (step_r == 2'd0) begin
        next_data_s = bcd_to_char(snap_tens_r);
      end else begin
        next_data_s = bcd_to_char(snap_units_r);
      end
    end else begin
      next_data_s = 8'h00;
      next_rs_s   = 1'b0;
      last_step_s = 1'b0;
    end
  end

  // Top sequencer and write sub-sequencer sharing one counter; all bus outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_state_r  <= ST_PWRON;
      wr_state_r   <= W_SU;
      step_r       <= 2'd0;
      cnt_r        <= LD_PWRON;
      snap_tens_r  <= 4'hF;
      snap_units_r <= 4'hF;
      lcd_data_r   <= 8'h00;
      lcd_rs_r     <= 1'b0;
      lcd_e_r      <= 1'b0;
      init_done_r  <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      case (top_state_r)
        ST_PWRON: begin
          if (cnt_done_s) begin
            top_state_r <= ST_INIT;
            wr_state_r  <= W_SU;
            step_r      <= 2'd0;
            lcd_data_r  <= init_cmd(2'd0);
            lcd_rs_r    <= 1'b0;
            cnt_r       <= LD_SU;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        ST_INIT, ST_REFRESH: begin
          case (wr_state_r)
            W_SU: begin
              if (cnt_done_s) begin
                wr_state_r <= W_PW;
                lcd_e_r    <= 1'b1;
                cnt_r      <= LD_PW;
              end else begin
                cnt_r <= cnt_r - CNT_ONE;
              end
            end

            W_PW: begin
              if (cnt_done_s) begin
                wr_state_r <= W_EX;
                lcd_e_r    <= 1'b0;
                cnt_r      <= is_clear_s ? LD_CLR : LD_EXEC;
              end else begin
                cnt_r <= cnt_r - CNT_ONE;
              end
            end

            W_EX: begin
              if (cnt_done_s) begin
                if (last_step_s) begin
                  // Sequence finished; init_done sticks until the next reset.
                  top_state_r <= ST_IDLE;
                  wr_state_r  <= W_SU;
                  step_r      <= 2'd0;
                  cnt_r       <= CNT_ZERO;
                  busy_r      <= 1'b0;
                  init_done_r <= 1'b1;
                end else begin
                  // Next write starts immediately, no gap cycle.
                  wr_state_r <= W_SU;
                  step_r     <= step_r + 2'd1;
                  lcd_data_r <= next_data_s;
                  lcd_rs_r   <= next_rs_s;
                  cnt_r      <= LD_SU;
                end
              end else begin
                cnt_r <= cnt_r - CNT_ONE;
              end
            end

            default: begin
              wr_state_r <= W_SU;
              lcd_e_r    <= 1'b0;
              cnt_r      <= LD_SU;
            end
          endcase
        end

        ST_IDLE: begin
          if (digit_change_s) begin
            // Freeze the digits; the refresh shows exactly this pair.
            snap_tens_r  <= digit_tens;
            snap_units_r <= digit_units;
            top_state_r  <= ST_REFRESH;
            wr_state_r   <= W_SU;
            step_r       <= 2'd0;
            lcd_data_r   <= CMD_DDRAM0;
            lcd_rs_r     <= 1'b0;
            cnt_r        <= LD_SU;
            busy_r       <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: restart the full power-on sequence.
          top_state_r <= ST_PWRON;
          wr_state_r  <= W_SU;
          step_r      <= 2'd0;
          cnt_r       <= LD_PWRON;
          lcd_e_r     <= 1'b0;
          init_done_r <= 1'b0;
          busy_r      <= 1'b1;
        end
      endcase
    end
  end

  assign lcd_data  = lcd_data_r;
  assign lcd_rs    = lcd_rs_r;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_r;
  assign init_done = init_done_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_lcd_digit_writer.sv
// Testbench for lcd_digit_writer: a cycle-level reference model built from a
// queue of expected bus cycles, checked every cycle, plus directed and random
// digit stimulus with literal expectations for the key timing points.
module tb_lcd_digit_writer;

  localparam int T_PWRON = 10;
  localparam int T_SU    = 2;
  localparam int T_PW    = 3;
  localparam int T_EXEC  = 5;
  localparam int T_CLR   = 8;
  localparam int T_WR    = T_SU + T_PW + T_EXEC;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_tens;
  logic [3:0] digit_units;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic       init_done;
  logic       busy;

  lcd_digit_writer #(
    .T_PWRON(T_PWRON),
    .T_SU   (T_SU),
    .T_PW   (T_PW),
    .T_EXEC (T_EXEC),
    .T_CLR  (T_CLR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_tens (digit_tens),
    .digit_units(digit_units),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .init_done  (init_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       rs;
    logic       e;
    logic       busy;
    logic       init;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  exp_t       mq[$];
  exp_t       m_exp;
  logic [3:0] m_tens;
  logic [3:0] m_units;
  logic [7:0] m_data;
  logic       m_rs;

  // Observed bus history
  logic [8:0] wlog[$];
  int         rise_cyc[$];
  int         fall_cyc[$];
  int         init_cyc;
  int         busy_fall_cyc;
  logic       prev_e;
  logic       prev_busy;
  int         e_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] char_of(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : 8'h2D;
  endfunction

  // One LCD write expands into its setup, strobe and execution cycles.
  task automatic push_write(input logic [7:0] d, input logic rs, input logic ini);
    int ex;
    ex = (!rs && d == 8'h01) ? T_CLR : T_EXEC;
    for (int i = 0; i < T_SU; i++) mq.push_back(exp_t'({d, rs, 1'b0, 1'b1, ini}));
    for (int i = 0; i < T_PW; i++) mq.push_back(exp_t'({d, rs, 1'b1, 1'b1, ini}));
    for (int i = 0; i < ex; i++)   mq.push_back(exp_t'({d, rs, 1'b0, 1'b1, ini}));
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < T_PWRON; i++) mq.push_back(exp_t'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    push_write(8'h38, 1'b0, 1'b0);
    push_write(8'h0C, 1'b0, 1'b0);
    push_write(8'h06, 1'b0, 1'b0);
    push_write(8'h01, 1'b0, 1'b0);
    m_tens  = 4'hF;
    m_units = 4'hF;
    m_data  = 8'h01;
    m_rs    = 1'b0;
  endtask

  // Reference model step and full output comparison every cycle, plus pulse bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      model_reset();
      m_exp = exp_t'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
      wlog.delete();
      rise_cyc.delete();
      fall_cyc.delete();
      init_cyc      = -1;
      busy_fall_cyc = -1;
      prev_e        = 1'b0;
      prev_busy     = 1'b1;
      e_run         = 0;
    end else begin
      if (mq.size() > 0) begin
        m_exp = mq.pop_front();
      end else begin
        m_exp = exp_t'({m_data, m_rs, 1'b0, 1'b0, 1'b1});
        if (digit_tens != m_tens || digit_units != m_units) begin
          m_tens  = digit_tens;
          m_units = digit_units;
          push_write(8'h80, 1'b0, 1'b1);
          push_write(char_of(m_tens), 1'b1, 1'b1);
          push_write(char_of(m_units), 1'b1, 1'b1);
          m_data = char_of(m_units);
          m_rs   = 1'b1;
        end
      end
      if (lcd_e && !prev_e) begin
        wlog.push_back({lcd_rs, lcd_data});
        rise_cyc.push_back(cyc);
        e_run = 1;
      end else if (lcd_e) begin
        e_run++;
      end else if (prev_e) begin
        fall_cyc.push_back(cyc);
        check("e_high_width", 32'(e_run), 32'(T_PW));
      end
      if (init_done && init_cyc < 0) init_cyc = cyc;
      if (!busy && prev_busy) busy_fall_cyc = cyc;
      prev_e    = lcd_e;
      prev_busy = busy;
    end
    check("outputs{data,rs,rw,e,busy,init_done}",
          32'({lcd_data, lcd_rs, lcd_rw, lcd_e, busy, init_done}),
          32'({m_exp.data, m_exp.rs, 1'b0, m_exp.e, m_exp.busy, m_exp.init}));
    cyc++;
  end

  task automatic wait_writes(input int n, input int bound);
    int i;
    i = 0;
    while (wlog.size() < n && i < bound) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (wlog.size() < n) begin
      tests++;
      fails++;
      $display("FAIL wait_writes: got %0d writes, expected %0d", wlog.size(), n);
    end
  endtask

  task automatic wait_idle(input int bound);
    int i;
    i = 0;
    @(negedge clk);
    #1;
    while (busy !== 1'b0 && i < bound) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (busy !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, expected 0", busy, bound);
    end
  endtask

  task automatic check_w(input string name, input int idx, input logic [8:0] exp);
    if (idx < wlog.size()) begin
      check(name, 32'(wlog[idx]), 32'(exp));
    end else begin
      tests++;
      fails++;
      $display("FAIL %s: write %0d missing, expected 0x%0h", name, idx, exp);
    end
  endtask

  task automatic drive_digits(input logic [3:0] t, input logic [3:0] u);
    @(posedge clk);
    #2;
    digit_tens  = t;
    digit_units = u;
  endtask

  initial begin
    int r;
    int n;
    int base;
    int e_cnt;
    int b_cnt;

    rst         = 1'b1;
    digit_tens  = 4'd0;
    digit_units = 4'd5;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    r = cyc;

    // Init sequence and the forced first refresh
    wait_writes(7, 400);
    wait_idle(200);
    check("pwron_to_first_e", 32'(rise_cyc[0] - r), 32'(T_PWRON + T_SU));
    check("back_to_back_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'(T_WR));
    check("clear_wait", 32'(init_cyc - fall_cyc[3]), 32'(T_CLR));
    check_w("init_38", 0, 9'h038);
    check_w("init_0c", 1, 9'h00C);
    check_w("init_06", 2, 9'h006);
    check_w("init_01", 3, 9'h001);
    check_w("ref1_80", 4, 9'h080);
    check_w("ref1_30", 5, 9'h130);
    check_w("ref1_35", 6, 9'h135);

    // Digit change in IDLE
    drive_digits(4'd4, 4'd2);
    n    = cyc;
    base = wlog.size();
    wait_writes(base + 3, 200);
    wait_idle(200);
    check("change_latency", 32'(rise_cyc[base] - n), 32'(1 + T_SU));
    check_w("chg_80", base, 9'h080);
    check_w("chg_34", base + 1, 9'h134);
    check_w("chg_32", base + 2, 9'h132);
    check("busy_return", 32'(busy_fall_cyc - (n + 1)), 32'(3 * T_WR));

    // Invalid digit shows as '-'
    drive_digits(4'd4, 4'hA);
    base = wlog.size();
    wait_writes(base + 3, 200);
    wait_idle(200);
    check_w("inv_80", base, 9'h080);
    check_w("inv_34", base + 1, 9'h134);
    check_w("inv_2d", base + 2, 9'h12D);

    // Change during refresh completes old snapshot then refreshes again
    drive_digits(4'd0, 4'd5);
    base = wlog.size();
    wait_writes(base + 1, 100);
    drive_digits(4'd0, 4'd4);
    wait_writes(base + 6, 300);
    wait_idle(200);
    check_w("dr_80a", base, 9'h080);
    check_w("dr_30a", base + 1, 9'h130);
    check_w("dr_35", base + 2, 9'h135);
    check_w("dr_80b", base + 3, 9'h080);
    check_w("dr_30b", base + 4, 9'h130);
    check_w("dr_34", base + 5, 9'h134);
    check("rerefresh_gap", 32'(rise_cyc[base + 3] - fall_cyc[base + 2]), 32'(T_EXEC + 1 + T_SU));

    // Random digit traffic, judged by the per-cycle model
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 45)) @(posedge clk);
      @(posedge clk);
      #2;
      if ($urandom_range(0, 3) != 0) digit_tens = 4'($urandom_range(0, 15));
      digit_units = 4'($urandom_range(0, 15));
    end
    repeat (100) @(posedge clk);
    wait_idle(200);

    // Reset while E is high
    drive_digits(4'd9, 4'd9);
    base = wlog.size();
    wait_writes(base + 1, 100);
    rst = 1'b0;
    #1;
    check("rst_lcd_e", 32'(lcd_e), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_lcd_data", 32'(lcd_data), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    r = cyc;
    wait_writes(7, 400);
    wait_idle(200);
    check("re_pwron_to_first_e", 32'(rise_cyc[0] - r), 32'(T_PWRON + T_SU));
    check_w("reinit_38", 0, 9'h038);
    check_w("reinit_0c", 1, 9'h00C);
    check_w("reinit_06", 2, 9'h006);
    check_w("reinit_01", 3, 9'h001);
    check_w("reref_80", 4, 9'h080);
    check_w("reref_39a", 5, 9'h139);
    check_w("reref_39b", 6, 9'h139);

    // Constant digits: bus stays quiet
    e_cnt = 0;
    b_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (lcd_e) e_cnt++;
      if (busy) b_cnt++;
    end
    check("quiet_e_cycles", 32'(e_cnt), 32'd0);
    check("quiet_busy_cycles", 32'(b_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_digit_writer.md
# lcd_digit_writer

Display-side consumer for the BCD countdown timer digits. Takes the tens and units digit values presented by the timer digit chain, converts them to ASCII, and writes them to an HD44780-compatible character LCD over an 8-bit parallel bus. On reset it runs the LCD power-on initialisation sequence. After that it rewrites the two display characters whenever either digit value changes.

## Interface
Parameters (cycle counts of `clk`):
- `T_PWRON`, 750000, power-on wait before the first command (15 ms at 50 MHz).
- `T_SU`, 2, RS/data setup time with `lcd_e` low, before the E pulse.
- `T_PW`, 12, `lcd_e` high width.
- `T_EXEC`, 2000, wait after E falls for normal commands and data writes.
- `T_CLR`, 82000, wait after E falls for the clear-display command (0x01).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `digit_tens`  in  4  BCD tens digit from the timer chain.
- `digit_units`  in  4  BCD units digit from the timer chain.
- `lcd_data`  out  8  LCD DB7..DB0.
- `lcd_rs`  out  1  0 = command, 1 = data.
- `lcd_rw`  out  1  held at 0 (write only).
- `lcd_e`  out  1  LCD enable strobe.
- `init_done`  out  1  goes high once the init sequence completes; stays high until reset.
- `busy`  out  1  high whenever the top FSM is not in IDLE.

## Operation
- Reset values: `lcd_data`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `init_done`=0, `busy`=1. Both snapshot registers reset to 4'hF, which forces the first refresh.
- Top FSM states: PWRON, INIT, IDLE, REFRESH.
  - PWRON counts `T_PWRON` cycles, then goes to INIT.
  - INIT issues commands 0x38, 0x0C, 0x06, 0x01 in that order. After the last write completes it sets `init_done`=1 and goes to IDLE.
  - IDLE: if `digit_tens`≠`snap_tens` or `digit_units`≠`snap_units`, it latches both inputs into the snapshots and goes to REFRESH. Otherwise it stays in IDLE with `busy`=0.
  - REFRESH issues three writes: command 0x80 (DDRAM address 0), then data char(`snap_tens`), then data char(`snap_units`). It then returns to IDLE.
- char(d) = 0x30+d for d ≤ 9. Values 10..15 display as 0x2D ('-').
- Write sub-FSM states: W_SU, W_PW, W_EX.
  - W_SU drives `lcd_rs` and `lcd_data`, holds `lcd_e`=0 for `T_SU` cycles.
  - W_PW holds `lcd_e`=1 for `T_PW` cycles.
  - W_EX holds `lcd_e`=0 for `T_EXEC` cycles, or `T_CLR` cycles when the command was 0x01.
  - `lcd_rs` and `lcd_data` stay stable from W_SU entry until the next write's W_SU entry.
- Refresh uses snapshots only. Input changes during REFRESH do not alter that refresh. On return to IDLE the mismatch is detected and a new refresh starts.
- Inputs changing during PWRON or INIT are ignored. The first IDLE cycle always refreshes, because the snapshots hold 4'hF.
- Reset asserted mid-write: all outputs return to reset values asynchronously, and the full PWRON/INIT sequence reruns.
- One shared cycle counter, wide enough for max(`T_PWRON`, `T_CLR`). It reloads on every state or sub-state entry.

## Timing
- One write occupies exactly `T_SU`+`T_PW`+`T_EXEC` cycles (`T_CLR` instead of `T_EXEC` for 0x01). Consecutive writes are back-to-back with no gap cycle.
- First W_SU of INIT starts on the cycle after PWRON expires. PWRON lasts `T_PWRON` cycles after reset deassertion.
- Latency from input change to start of refresh:
  - Cycle N: IDLE samples a mismatch.
  - Cycle N+1: W_SU for 0x80 begins.
  - `lcd_e` rises at N+1+`T_SU`.
- `busy` falls in the first IDLE cycle. `init_done` rises in the same cycle as the first IDLE entry.
- A refresh takes 3·(`T_SU`+`T_PW`+`T_EXEC`) cycles.

## Test plan
All scenarios use `T_PWRON`=10, `T_SU`=2, `T_PW`=3, `T_EXEC`=5, `T_CLR`=8.
- **Init sequence.** Release reset with digits 0/5. Required: no `lcd_e` pulse for 10 cycles. Then E pulses with `lcd_rs`=0 and data 0x38, 0x0C, 0x06, 0x01, each E high exactly 3 cycles. The gap after 0x01 is 8 cycles. Then `init_done`=1, then a refresh writes 0x80, 0x30, 0x35 (the last two with `lcd_rs`=1).
- **Digit change.** In IDLE, change the digits to 4/2. Required: E rises 3 cycles after the change cycle (N+1+`T_SU`). Writes are 0x80, 0x34, 0x32. `busy` returns to 0 exactly 30 cycles after refresh entry.
- **Invalid digit.** Set `digit_units`=4'hA. Required: data write 0x2D.
- **Change during refresh.** Change units 5→4 during the 0x80 write. Required: the current refresh completes with the old snapshot 0x35. The next refresh starts the cycle after IDLE entry and writes 0x34.
- **Reset mid-write.** Assert `rst` low while `lcd_e`=1. Required: `lcd_e`=0, `init_done`=0, `busy`=1 immediately. After release the full init sequence repeats.
- **No change.** Hold the digits constant for 200 cycles after refresh. Required: no `lcd_e` activity and `busy`=0 throughout.
